// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the boot-time instruction
//                memory loader: FSM state encoding, word geometry and a
//                word-index to byte-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Loader FSM states. Encoded explicitly so waveforms read the same across
  // tools.
  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_BYTES_LOG2 = 2;

  // The word counter is one bit wider than the 16-bit length header, so a
  // count of 65535 can be compared and incremented without wrapping.
  localparam int WORD_CNT_W = 17;

  // Converts a word index into the matching word-aligned byte address, the
  // form the CPU uses for its PC.
  function automatic logic [WORD_CNT_W+WORD_BYTES_LOG2-1:0] word_to_byte_addr(
    input logic [WORD_CNT_W-1:0] word_idx
  );
    return {word_idx, {WORD_BYTES_LOG2{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Bundles the loader's byte-stream input, instruction-memory
//                write port and boot status outputs.
//                  rx_valid/rx_data/rx_ready : byte stream (valid/ready)
//                  imem_we/imem_addr/imem_wdata : instruction memory write
//                  cpu_rst/done/error : CPU reset hold and load status
//                Modport slave is the loader; modport master is the
//                surrounding system (byte source and status consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 32
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_rst,
    output done,
    output error
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_rst,
    input  done,
    input  error
  );

endinterface
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Packs accepted bytes into 32-bit little-endian words. The
//                first byte of a word lands in bits [7:0].
//                  clk, rst   : clock, synchronous active-high reset
//                  in_valid   : in_byte is accepted this cycle
//                  in_byte    : byte to pack
//                  word_valid : one-cycle pulse, combinational, in the cycle
//                               the fourth byte of a word is accepted
//                  word       : completed word, valid with word_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [WORD_BYTES_LOG2-1:0] c_last_byte =
    WORD_BYTES_LOG2'(BYTES_PER_WORD - 1);

  logic [WORD_BYTES_LOG2-1:0] r_byte_cnt;
  logic [23:0]                r_low_bytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_low_bytes <= '0;
    end else if (in_valid) begin
      // The counter wraps naturally from the last byte back to 0.
      r_byte_cnt <= r_byte_cnt + WORD_BYTES_LOG2'(1);
      case (r_byte_cnt)
        2'd0:    r_low_bytes[7:0]   <= in_byte;
        2'd1:    r_low_bytes[15:8]  <= in_byte;
        2'd2:    r_low_bytes[23:16] <= in_byte;
        default: r_low_bytes        <= r_low_bytes;
      endcase
    end
  end

  // The top byte is taken straight from the input so the completed word is
  // available in the same cycle as its last handshake; the loader registers
  // it on the following edge.
  assign word_valid = in_valid && (r_byte_cnt == c_last_byte);
  assign word       = {in_byte, r_low_bytes};

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader in front of the instruction ROM.
//                Receives a frame  LEN_LO LEN_HI | 4*N payload bytes | XOR
//                checksum  over a valid/ready byte stream, writes each
//                little-endian word to word-aligned byte addresses and holds
//                the CPU in reset until the checksum has verified.
//                  clk, rst : clock, synchronous active-high reset
//                  bus      : imem_loader_if slave modport (byte stream,
//                             memory write port, cpu_rst/done/error)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [WORD_CNT_W-1:0] c_depth = WORD_CNT_W'(DEPTH_WORDS);

  state_t r_state;
  state_t w_state_next;

  logic                  w_rx_ready;
  logic                  w_hs;
  logic                  w_asm_valid;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  logic [15:0]           w_len;

  logic [7:0]            r_len_lo;
  logic [WORD_CNT_W-1:0] r_len;
  logic [WORD_CNT_W-1:0] r_word_cnt;
  logic [7:0]            r_csum;

  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_rst;
  logic                  r_done;
  logic                  r_error;

  // Ready is a pure state decode so a source may test it before presenting
  // a byte.
  assign w_rx_ready  = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                       (r_state == DATA)   || (r_state == CHECK);
  assign w_hs        = bus.rx_valid && w_rx_ready;
  assign w_asm_valid = w_hs && (r_state == DATA);
  assign w_len       = {bus.rx_data, r_len_lo};

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (w_asm_valid),
    .in_byte    (bus.rx_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LEN_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic; every transition needs a handshake.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LEN_LO: begin
        if (w_hs) begin
          w_state_next = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_hs) begin
          if ({1'b0, w_len} > c_depth) begin
            w_state_next = ERROR;
          end else if (w_len == 16'd0) begin
            w_state_next = CHECK;
          end else begin
            w_state_next = DATA;
          end
        end
      end
      DATA: begin
        // Leave once the final word's last byte has been accepted.
        if (w_word_valid && ((r_word_cnt + WORD_CNT_W'(1)) == r_len)) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (w_hs) begin
          w_state_next = (bus.rx_data == r_csum) ? DONE : ERROR;
        end
      end
      DONE:    w_state_next = DONE;
      ERROR:   w_state_next = ERROR;
      default: w_state_next = LEN_LO;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, checksum and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_hs && (r_state == LEN_LO)) begin
        r_len_lo <= bus.rx_data;
      end
      if (w_hs && (r_state == LEN_HI)) begin
        r_len <= {1'b0, w_len};
      end
      if (w_asm_valid) begin
        r_csum <= r_csum ^ bus.rx_data;
      end

      // Write port: strobe for one cycle after the last byte of a word;
      // address and data hold until the next word completes.
      r_we <= w_word_valid;
      if (w_word_valid) begin
        r_addr     <= ADDR_W'(word_to_byte_addr(r_word_cnt));
        r_wdata    <= w_word;
        r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
      end

      // DONE and ERROR are terminal, so these flags stay set until rst.
      if (w_state_next == DONE) begin
        r_done <= 1'b1;
      end
      if (w_state_next == ERROR) begin
        r_error <= 1'b1;
      end

      // Released one cycle after DONE is entered, by which point the last
      // word's write strobe has already retired.
      r_cpu_rst <= (r_state != DONE);
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_rst    = r_cpu_rst;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Drives frames
//                through the byte stream and compares the write log and
//                status outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int c_depth = 1024;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(
    .DEPTH_WORDS (c_depth),
    .ADDR_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  // One log entry per cycle the strobe is high, so a widened strobe shows up
  // as extra entries.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input int k,
                             input logic [31:0] addr, input logic [31:0] data);
    if (wr_addr_q.size() > k) begin
      check({tag, "_addr"}, wr_addr_q[k], addr);
      check({tag, "_data"}, wr_data_q[k], data);
    end else begin
      check({tag, "_present"}, 32'(wr_addr_q.size()), 32'(k + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Presents one byte for exactly one rising edge; returns 1 time unit after
  // that edge so status can be sampled right away.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes [$], input int gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] frame [$];

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);

    // ---------------- N=1 single word ----------------
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'hA0);
    check("n1_we_early", 32'(bus.imem_we), 32'd0);
    send_byte(8'hE3);
    check("n1_we_strobe", 32'(bus.imem_we), 32'd1);
    check("n1_addr", bus.imem_addr, 32'h0000_0000);
    check("n1_wdata", bus.imem_wdata, 32'hE3A0_0013);
    send_byte(8'h50);
    check("n1_we_after", 32'(bus.imem_we), 32'd0);
    check("n1_done", 32'(bus.done), 32'd1);
    check("n1_error", 32'(bus.error), 32'd0);
    check("n1_cpu_rst_held", 32'(bus.cpu_rst), 32'd1);
    check("n1_ready", 32'(bus.rx_ready), 32'd0);
    idle(1);
    check("n1_cpu_rst_rel", 32'(bus.cpu_rst), 32'd0);
    idle(3);
    check("n1_wdata_hold", bus.imem_wdata, 32'hE3A0_0013);
    check("n1_nwrites", 32'(wr_addr_q.size()), 32'd1);

    // ---------------- N=3 back-to-back ----------------
    do_reset();
    frame = '{8'h03, 8'h00,
              8'h44, 8'h33, 8'h22, 8'h11,
              8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h01, 8'h00, 8'h00, 8'h00,
              8'h67};
    send_frame(frame, 0);
    idle(2);
    check("n3_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check_write("n3_w0", 0, 32'h0, 32'h1122_3344);
    check_write("n3_w1", 1, 32'h4, 32'hDEAD_BEEF);
    check_write("n3_w2", 2, 32'h8, 32'h0000_0001);
    check("n3_done", 32'(bus.done), 32'd1);
    check("n3_cpu_rst", 32'(bus.cpu_rst), 32'd0);

    // ---------------- bad checksum ----------------
    do_reset();
    frame = '{8'h01, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h51};
    send_frame(frame, 0);
    idle(3);
    check("bad_cs_error", 32'(bus.error), 32'd1);
    check("bad_cs_done", 32'(bus.done), 32'd0);
    check("bad_cs_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("bad_cs_ready", 32'(bus.rx_ready), 32'd0);

    // ---------------- length above capacity (1025) ----------------
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    check("len_big_error", 32'(bus.error), 32'd1);
    check("len_big_ready", 32'(bus.rx_ready), 32'd0);
    frame = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(frame, 0);
    idle(3);
    check("len_big_nwrites", 32'(wr_addr_q.size()), 32'd0);
    check("len_big_done", 32'(bus.done), 32'd0);
    check("len_big_cpu_rst", 32'(bus.cpu_rst), 32'd1);

    // ---------------- N=0, good then bad checksum ----------------
    do_reset();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(frame, 0);
    idle(2);
    check("n0_done", 32'(bus.done), 32'd1);
    check("n0_error", 32'(bus.error), 32'd0);
    check("n0_nwrites", 32'(wr_addr_q.size()), 32'd0);
    do_reset();
    frame = '{8'h00, 8'h00, 8'h01};
    send_frame(frame, 0);
    idle(2);
    check("n0_bad_error", 32'(bus.error), 32'd1);
    check("n0_bad_done", 32'(bus.done), 32'd0);

    // ---------------- abort mid-load, reload with idle gaps ----------------
    do_reset();
    frame = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_frame(frame, 0);
    do_reset();
    idle(3);
    check("abort_nwrites", 32'(wr_addr_q.size()), 32'd0);
    check("abort_addr", bus.imem_addr, 32'd0);
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_frame(frame, 2);
    idle(2);
    check("abort_reload_nwrites", 32'(wr_addr_q.size()), 32'd1);
    check_write("abort_reload", 0, 32'h0, 32'h1234_5678);
    check("abort_reload_done", 32'(bus.done), 32'd1);

    // ---------------- N == DEPTH_WORDS ----------------
    // Word i is {24'h0, i[7:0]}; each low-byte value repeats four times, so
    // the XOR checksum is 0.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < c_depth; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      send_byte(iv[7:0]);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    send_byte(8'h00);
    idle(2);
    check("full_nwrites", 32'(wr_addr_q.size()), 32'(c_depth));
    check_write("full_last", c_depth - 1, 32'h0000_0FFC, 32'h0000_00FF);
    check("full_done", 32'(bus.done), 32'd1);
    check("full_error", 32'(bus.error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the CPU's instruction ROM.
- Accepts a byte stream on a valid/ready interface and assembles 32-bit little-endian words.
- Writes each word into instruction memory at word-aligned byte addresses, matching the CPU's PC addressing.
- Holds the CPU in reset until the image has loaded and its checksum has verified.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words; a length header above this is rejected.
- ADDR_W, 32, width of imem_addr, a byte address compatible with PC.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader accepts a byte this cycle; a handshake occurs when rx_valid & rx_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  write byte address, always a multiple of 4.
- imem_wdata  out  32  write data.
- cpu_rst  out  1  registered reset to the CPU; 1 = CPU held in reset.
- done  out  1  image loaded and checksum matched (sticky).
- error  out  1  bad length or checksum mismatch (sticky).

Behaviour:
- Reset is synchronous: on posedge clk with rst=1, the FSM goes to LEN_LO.
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0.
  - Byte counter = 0, word counter = 0, checksum = 0.
  - rst asserted mid-load aborts the load immediately; no further write strobe is issued.
- rx_ready is decoded from state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERROR. It does not depend on rx_valid.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count, little-endian), then 4*N payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
- FSM transitions, each taken on a handshake:
  - LEN_LO: capture low byte, go to LEN_HI.
  - LEN_HI: compute N.
    - N > DEPTH_WORDS: go to ERROR.
    - N == 0: go to CHECK (expected checksum 0).
    - Otherwise: go to DATA.
  - DATA:
    - Shift the byte in at position byte_cnt (byte 0 -> bits [7:0]) and XOR it into the checksum.
    - When byte_cnt wraps 3->0, register imem_we=1, imem_wdata=word, imem_addr=4*word_cnt on the next cycle, then increment word_cnt.
    - After word N-1 completes, go to CHECK.
  - CHECK: byte == checksum -> DONE, else -> ERROR.
  - DONE and ERROR: terminal until rst.
- Write latency: imem_we is high exactly one cycle, starting the cycle after the handshake of byte 3 of each word.
  - imem_addr and imem_wdata hold their values until the next write.
- Back-to-back bytes on consecutive cycles are accepted at full rate with no stall.
- Idle rx_valid=0 cycles stall the FSM with no state change.
- cpu_rst:
  - Deasserts (registered) the cycle after DONE is entered, i.e. after the final word write has completed.
  - Stays 1 in ERROR.
- done and error are mutually exclusive, sticky and registered.
- Width rules: word_cnt is 17 bits so a 65535-word compare cannot overflow; the checksum is 8 bits.
- N == DEPTH_WORDS is legal; the last address written is 4*(DEPTH_WORDS-1).

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - constants BYTES_PER_WORD=4 and WORD_BYTES_LOG2=2.
- Sub-module word_assembler owns the byte shift register and the 2-bit byte counter.
  - It takes in_valid and in_byte, and produces word_valid (one-cycle pulse) and word[31:0].
- The top level holds the FSM, counters, checksum and output registers.

Test Plan:
- Reset, then frame 01 00 | 13 00 A0 E3 | checksum 0x50 -> one imem_we at addr 0 with wdata 0xE3A00013; done=1; cpu_rst falls the cycle after DONE; rx_ready=0 afterwards.
- N=3 with bytes sent on consecutive cycles -> three writes at addr 0, 4, 8, each strobe exactly one cycle wide, with the correct little-endian data.
- Same frame with a wrong checksum byte -> error=1, done=0, cpu_rst stays 1, rx_ready=0.
- Length header DEPTH_WORDS+1 -> ERROR right after the LEN_HI handshake; no imem_we is ever asserted.
- N=0 followed by checksum 0x00 -> done=1 with no writes; checksum 0x01 instead -> error=1.
- rst pulsed after 6 payload bytes, then a full N=1 frame -> no write from the aborted frame; the new word is written at addr 0 and done=1.
